// File: rtl/dmem_bus_unit.sv
// dmem_bus_unit: load/store unit between the MEM stage and a variable-latency
// word-wide data bus. Turns one MEM-stage access into a word-aligned bus
// transaction with byte enables, returns sign/zero-extended load data and
// freezes the pipeline (mem_stall) until the bus answers or times out.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   memread_MEM, memwrite_MEM    access strobes (write wins when both set)
//   funct3_MEM                   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_MEM                      byte address
//   writedata_MEM                store data (low bits)
//   readdata_MEM                 extended load result (registered)
//   mem_stall                    pipeline freeze request (combinational)
//   misalign, bus_err            one-cycle pulses (registered)
//   bus_req/we/addr/be/wdata     bus request side (registered)
//   bus_ack, bus_rdata           bus response side
module dmem_bus_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  output logic [31:0] readdata_MEM,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [DATA_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;

  logic                access_c;
  logic                misaligned_c;
  logic [3:0]          be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [7:0]          lane_byte_c;
  logic [15:0]         lane_half_c;
  logic [DATA_W-1:0]   load_ext_c;

  // Request decode; funct3[1:0] selects the size, 011/110/111 fall into word.
  always_comb begin
    access_c     = memread_MEM | memwrite_MEM;
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = writedata_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_MEM[1:0];
        wdata_c = {4{writedata_MEM[7:0]}};
      end
      2'b01: begin
        misaligned_c = alu_MEM[0];
        be_c         = alu_MEM[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{writedata_MEM[15:0]}};
      end
      default: begin
        misaligned_c = |alu_MEM[1:0];
      end
    endcase
    // Loads always fetch the full word; lane selection happens on return.
    if (!memwrite_MEM) begin
      be_c = 4'b1111;
    end
  end

  // Lane select and extension of the returning word, using the latched request.
  always_comb begin
    lane_byte_c = bus_rdata[{off_q, 3'b000} +: 8];
    lane_half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext_c = f3_q[2] ? {24'd0, lane_byte_c}
                                    : {{24{lane_byte_c[7]}}, lane_byte_c};
      2'b01:   load_ext_c = f3_q[2] ? {16'd0, lane_half_c}
                                    : {{16{lane_half_c[15]}}, lane_half_c};
      default: load_ext_c = bus_rdata;
    endcase
  end

  // Freeze while a transaction is being accepted or is in flight.
  always_comb begin
    mem_stall = 1'b0;
    if (state_q == S_BUSY) begin
      mem_stall = 1'b1;
    end else if (state_q == S_IDLE) begin
      mem_stall = access_c & ~misaligned_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    readdata_d  = readdata_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          if (misaligned_c) begin
            misalign_d = 1'b1;
            if (!memwrite_MEM) begin
              readdata_d = '0;
            end
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = memwrite_MEM;
            bus_addr_d  = {alu_MEM[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
            f3_d        = funct3_MEM;
            off_d       = alu_MEM[1:0];
            cnt_d       = '0;
            state_d     = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle still completes normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            readdata_d = load_ext_c;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) begin
            readdata_d = '0;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      readdata_q  <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      readdata_q  <= readdata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign readdata_MEM = readdata_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_unit.sv
// Bench for dmem_bus_unit: directed accesses with hand-computed results plus
// a transaction-level reference model compared against every output each cycle.
module tb_dmem_bus_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread_MEM = 1'b0;
  logic        memwrite_MEM = 1'b0;
  logic [2:0]  funct3_MEM = 3'b000;
  logic [31:0] alu_MEM = 32'd0;
  logic [31:0] writedata_MEM = 32'd0;
  logic [31:0] readdata_MEM;
  logic        mem_stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  dmem_bus_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
    .funct3_MEM(funct3_MEM), .alu_MEM(alu_MEM), .writedata_MEM(writedata_MEM),
    .readdata_MEM(readdata_MEM), .mem_stall(mem_stall),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (access-size arithmetic) ----------------
  function automatic int unsigned sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % sz(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
    int unsigned m;
    if (!we) return 4'hF;
    m = ((32'd1 << sz(f3)) - 32'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (sz(f3) == 1) return 32'(wd[7:0]) * 32'h01010101;
    if (sz(f3) == 2) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] r, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v, span;
    int unsigned n;
    n = sz(f3);
    if (n == 4) return r;
    v    = r >> (8 * int'(off));
    span = 32'd1 << (8 * n);
    v    = v & (span - 32'd1);
    if (!f3[2] && v >= span / 2) v = v - span;
    return v;
  endfunction

  logic [31:0] m_rd, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_req, m_we, m_mis, m_err, m_done;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int          m_busy;   // -1 when no bus transaction; else BUSY cycles already spent

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rd <= '0; m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_req <= 1'b0; m_we <= 1'b0; m_mis <= 1'b0; m_err <= 1'b0; m_done <= 1'b0;
      m_f3 <= '0; m_off <= '0; m_busy <= -1;
    end else begin
      m_mis <= 1'b0;
      m_err <= 1'b0;
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_busy >= 0) begin
        if (bus_ack) begin
          if (!m_we) m_rd <= model_load(bus_rdata, m_f3, m_off);
          m_req <= 1'b0; m_busy <= -1; m_done <= 1'b1;
        end else if (m_busy + 1 >= TO) begin
          if (!m_we) m_rd <= '0;
          m_err <= 1'b1; m_req <= 1'b0; m_busy <= -1; m_done <= 1'b1;
        end else begin
          m_busy <= m_busy + 1;
        end
      end else if (memread_MEM || memwrite_MEM) begin
        if (model_mis(funct3_MEM, alu_MEM)) begin
          m_mis <= 1'b1;
          if (!memwrite_MEM) m_rd <= '0;
        end else begin
          m_req   <= 1'b1;
          m_we    <= memwrite_MEM;
          m_addr  <= alu_MEM & 32'hFFFF_FFFC;
          m_be    <= model_be(memwrite_MEM, funct3_MEM, alu_MEM[1:0]);
          m_wdata <= model_wdata(funct3_MEM, writedata_MEM);
          m_f3    <= funct3_MEM;
          m_off   <= alu_MEM[1:0];
          m_busy  <= 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic exp_stall;
    if (!rst) begin
      exp_stall = (m_busy >= 0) ||
                  (!m_done && (memread_MEM || memwrite_MEM) && !model_mis(funct3_MEM, alu_MEM));
      chk("readdata_MEM", readdata_MEM, m_rd);
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("bus_err", 32'(bus_err), 32'(m_err));
      chk("bus_req", 32'(bus_req), 32'(m_req));
      chk("bus_we", 32'(bus_we), 32'(m_we));
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_be", 32'(bus_be), 32'(m_be));
      chk("bus_wdata", bus_wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  // Presents one access and plays the bus: ack in the ack_n-th request cycle
  // (0 = never). Returns after the cycle in which the pipeline is released.
  task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int ack_n, input logic [31:0] rdat,
                     output int stall_n, output int req_n, output int err_n);
    bit released;
    memread_MEM = rd; memwrite_MEM = wr; funct3_MEM = f3;
    alu_MEM = addr; writedata_MEM = wd; bus_rdata = rdat;
    stall_n = 0; req_n = 0; err_n = 0; released = 1'b0;
    for (int k = 0; k < 40 && !released; k++) begin
      @(negedge clk);
      if (mem_stall) stall_n++;
      if (bus_req) req_n++;
      if (bus_err) err_n++;
      released = !mem_stall;
      bus_ack = bus_req && (req_n == ack_n);
      @(posedge clk); #2;
      bus_ack = 1'b0;
    end
    if (!released) chk("run_released", 32'd0, 32'd1);
    memread_MEM = 1'b0; memwrite_MEM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s, r, e;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_readdata", readdata_MEM, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_mem_stall", 32'(mem_stall), 32'h0);
    rst = 1'b0;
    @(posedge clk); #2;

    // LW 0x100, zero-wait
    run(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, s, r, e);
    chk("lw_stall", 32'(s), 32'd2);
    chk("lw_req", 32'(r), 32'd1);
    chk("lw_data", readdata_MEM, 32'hDEADBEEF);
    chk("lw_addr", bus_addr, 32'h100);
    chk("lw_be", 32'(bus_be), 32'hF);

    run(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0102, s, r, e);
    chk("lb_data", readdata_MEM, 32'hFFFFFF80);
    run(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0102, s, r, e);
    chk("lbu_data", readdata_MEM, 32'h00000080);
    run(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF0102, s, r, e);
    chk("lhu_data", readdata_MEM, 32'h000080FF);
    run(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF0102, s, r, e);
    chk("lh_data", readdata_MEM, 32'hFFFF80FF);
    chk("lh_stall", 32'(s), 32'd3);

    // SB 0x5A at 0x201, ack in 4th request cycle
    run(0, 1, 3'b000, 32'h201, 32'h1234565A, 4, 32'h0, s, r, e);
    chk("sb_stall", 32'(s), 32'd5);
    chk("sb_we", 32'(bus_we), 32'd1);
    chk("sb_be", 32'(bus_be), 32'b0010);
    chk("sb_wdata", bus_wdata, 32'h5A5A5A5A);
    chk("sb_readdata", readdata_MEM, 32'hFFFF80FF);

    // SH at 0x202, both strobes set -> write
    run(1, 1, 3'b001, 32'h202, 32'h0000BEEF, 1, 32'h0, s, r, e);
    chk("sh_we", 32'(bus_we), 32'd1);
    chk("sh_be", 32'(bus_be), 32'b1100);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    chk("sh_readdata", readdata_MEM, 32'hFFFF80FF);

    // funct3 011 behaves as a word load
    run(1, 0, 3'b011, 32'h104, 32'h0, 1, 32'hCAFEF00D, s, r, e);
    chk("f3_011_data", readdata_MEM, 32'hCAFEF00D);

    // misaligned LW, then misaligned SH
    run(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, s, r, e);
    chk("mis_lw_pulse", 32'(misalign), 32'd1);
    chk("mis_lw_stall", 32'(s), 32'd0);
    chk("mis_lw_req", 32'(r), 32'd0);
    chk("mis_lw_data", readdata_MEM, 32'h0);
    run(1, 0, 3'b010, 32'h108, 32'h0, 3, 32'h11112222, s, r, e);
    chk("lw108_data", readdata_MEM, 32'h11112222);
    run(0, 1, 3'b001, 32'h101, 32'hFFFF, 1, 32'h0, s, r, e);
    chk("mis_sh_pulse", 32'(misalign), 32'd1);
    chk("mis_sh_req", 32'(r), 32'd0);
    chk("mis_sh_data", readdata_MEM, 32'h11112222);

    // timeout on a load
    run(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h55555555, s, r, e);
    chk("to_req", 32'(r), 32'd4);
    chk("to_stall", 32'(s), 32'd5);
    chk("to_err", 32'(e), 32'd1);
    chk("to_data", readdata_MEM, 32'h0);

    // late ack is ignored
    bus_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    bus_ack = 1'b0;
    chk("late_req", 32'(bus_req), 32'd0);
    chk("late_data", readdata_MEM, 32'h0);

    // reset in 2nd BUSY cycle
    run(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h12345678, s, r, e);
    chk("pre_rst_data", readdata_MEM, 32'h12345678);
    memread_MEM = 1'b1; funct3_MEM = 3'b010; alu_MEM = 32'h400;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("busy2_req", 32'(bus_req), 32'd1);
    rst = 1'b1; memread_MEM = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_data", readdata_MEM, 32'h0);
    chk("arst_addr", bus_addr, 32'h0);
    chk("arst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run(1, 0, 3'b010, 32'h500, 32'h0, 2, 32'h0BADCAFE, s, r, e);
    chk("post_rst_data", readdata_MEM, 32'h0BADCAFE);
    chk("post_rst_stall", 32'(s), 32'd3);
    chk("post_rst_addr", bus_addr, 32'h500);

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
